// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - shared state encoding and constants for the LCD SPI controller
package lcd_pkg;

    typedef enum logic [1:0] {
        RST_ASSERT = 2'd0,
        RST_WAIT   = 2'd1,
        IDLE       = 2'd2,
        SHIFT      = 2'd3
    } lcd_state_t;

    localparam int DC_BIT = 8;
    localparam int PWM_W  = 8;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/lcd_bl_pwm.sv
// rtl/lcd_bl_pwm.sv - free-running 8-bit backlight PWM with period-aligned duty update
module lcd_bl_pwm
    import lcd_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [PWM_W-1:0] duty,
    output logic             pwm_o
);

    logic [PWM_W-1:0] pwm_cnt;
    logic [PWM_W-1:0] duty_q;

    // Duty is only sampled on the last count so each period uses one value throughout.
    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_cnt <= '0;
            duty_q  <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
            if (pwm_cnt == {PWM_W{1'b1}}) begin
                duty_q <= duty;
            end
        end
    end

    assign pwm_o = (pwm_cnt < duty_q);

endmodule

// File: rtl/lcd_spi_ctrl.sv
// rtl/lcd_spi_ctrl.sv - LCD panel reset sequencer, 9-bit SPI byte shifter and backlight PWM
module lcd_spi_ctrl
    import lcd_pkg::*;
#(
    parameter int CLK_DIV      = 4,
    parameter int RESET_CYCLES = 1000,
    parameter int WAKE_CYCLES  = 5000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       init_req,
    input  logic       s_valid,
    output logic       s_ready,
    input  logic [8:0] s_data,
    input  logic [7:0] bl_duty,
    output logic       busy,
    output logic       lcd_scl,
    output logic       lcd_sda,
    output logic       lcd_dc,
    output logic       lcd_res,
    output logic       lcd_backlight
);

    localparam int MAX_CYC = max3(RESET_CYCLES, WAKE_CYCLES, 16 * CLK_DIV);
    localparam int CNT_W   = $clog2(MAX_CYC) + 1;

    localparam logic [CNT_W-1:0] RST_LAST   = CNT_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] WAKE_LAST  = CNT_W'(WAKE_CYCLES - 1);
    localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(16 * CLK_DIV - 1);
    localparam logic [7:0]       DIV_LAST   = 8'(CLK_DIV - 1);

    lcd_state_t       state;
    lcd_state_t       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [7:0]       div_cnt;
    logic [7:0]       shreg;
    logic             accept;
    logic             scl_tick;

    assign accept   = s_valid && s_ready;
    assign scl_tick = (div_cnt == DIV_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RST_ASSERT;
        end else begin
            state <= state_nxt;
        end
    end

    // init_req is deliberately absent from RST_ASSERT so a repeat request cannot stretch the reset.
    always_comb begin
        state_nxt = state;
        case (state)
            RST_ASSERT: if (cnt == RST_LAST)   state_nxt = RST_WAIT;
            RST_WAIT:   if (init_req)          state_nxt = RST_ASSERT;
                        else if (cnt == WAKE_LAST) state_nxt = IDLE;
            IDLE:       if (init_req)          state_nxt = RST_ASSERT;
                        else if (s_valid)      state_nxt = SHIFT;
            SHIFT:      if (init_req)          state_nxt = RST_ASSERT;
                        else if (cnt == SHIFT_LAST) state_nxt = IDLE;
            default:                           state_nxt = RST_ASSERT;
        endcase
    end

    always_comb begin
        busy    = (state != IDLE);
        s_ready = (state == IDLE) && !init_req;
        lcd_res = (state != RST_ASSERT);
    end

    // Every state change restarts the counters and parks SCL low; SDA/DC keep their last values.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            div_cnt <= '0;
            shreg   <= '0;
            lcd_scl <= 1'b0;
            lcd_sda <= 1'b0;
            lcd_dc  <= 1'b0;
        end else if (state_nxt != state) begin
            cnt     <= '0;
            div_cnt <= '0;
            lcd_scl <= 1'b0;
            if (accept) begin
                shreg   <= s_data[7:0];
                lcd_dc  <= s_data[DC_BIT];
                lcd_sda <= s_data[7];
            end
        end else if (state != IDLE) begin
            cnt <= cnt + 1'b1;
            if (state == SHIFT) begin
                div_cnt <= scl_tick ? 8'd0 : div_cnt + 8'd1;
                if (scl_tick) begin
                    lcd_scl <= ~lcd_scl;
                    if (lcd_scl) begin
                        shreg   <= {shreg[6:0], 1'b0};
                        lcd_sda <= shreg[6];
                    end
                end
            end
        end
    end

    lcd_bl_pwm u_bl_pwm (
        .clk   (clk),
        .rst   (rst),
        .duty  (bl_duty),
        .pwm_o (lcd_backlight)
    );

endmodule

// File: tb/tb_lcd_spi_ctrl.sv
// tb/tb_lcd_spi_ctrl.sv - self-checking bench for lcd_spi_ctrl
module tb_lcd_spi_ctrl;

    logic       clk      = 1'b0;
    logic       rst      = 1'b1;
    logic       init_req = 1'b0;
    logic       s_valid  = 1'b0;
    logic [8:0] s_data   = 9'h000;
    logic [7:0] bl_duty  = 8'h00;
    logic       s_ready;
    logic       busy;
    logic       lcd_scl;
    logic       lcd_sda;
    logic       lcd_dc;
    logic       lcd_res;
    logic       lcd_backlight;

    int total = 0;
    int bad   = 0;

    lcd_spi_ctrl #(
        .CLK_DIV      (2),
        .RESET_CYCLES (10),
        .WAKE_CYCLES  (20)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .init_req      (init_req),
        .s_valid       (s_valid),
        .s_ready       (s_ready),
        .s_data        (s_data),
        .bl_duty       (bl_duty),
        .busy          (busy),
        .lcd_scl       (lcd_scl),
        .lcd_sda       (lcd_sda),
        .lcd_dc        (lcd_dc),
        .lcd_res       (lcd_res),
        .lcd_backlight (lcd_backlight)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [8:0] data;
        logic       exp_dc;
        logic [7:0] exp_bits;
    } vec_t;

    vec_t vecs[5];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_ready(input string name);
        int n;
        n = 0;
        while (s_ready !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        check(name, s_ready, 1);
    endtask

    // Sends one byte from IDLE and observes the SHIFT phase until s_ready returns.
    task automatic send_and_watch(input logic [8:0] d, output logic dc_first, output logic sda_first,
                                  output logic scl_first, output logic [7:0] bits, output int ready_low,
                                  output int rises, output int period_bad, output logic dc_changed);
        int   n;
        int   last_rise;
        logic prev_scl;
        bits       = 8'h00;
        rises      = 0;
        ready_low  = 0;
        period_bad = 0;
        dc_changed = 1'b0;
        last_rise  = -1;
        s_valid = 1'b1;
        s_data  = d;
        tick();
        s_valid   = 1'b0;
        dc_first  = lcd_dc;
        sda_first = lcd_sda;
        scl_first = lcd_scl;
        prev_scl  = 1'b0;
        n = 0;
        while (s_ready !== 1'b1 && n < 100) begin
            ready_low++;
            if (lcd_dc !== dc_first) dc_changed = 1'b1;
            if (lcd_scl && !prev_scl) begin
                bits = {bits[6:0], lcd_sda};
                if (last_rise >= 0 && (n - last_rise) != 4) period_bad++;
                last_rise = n;
                rises++;
            end
            prev_scl = lcd_scl;
            tick();
            n++;
        end
    endtask

    logic       dc_first, sda_first, scl_first, dc_changed, dc_a, prev;
    logic [7:0] bits;
    int         ready_low, rises, period_bad, c, hi, lo, res_low, n;
    logic       got;

    initial begin
        vecs[0] = '{9'h1A5, 1'b1, 8'b1010_0101};
        vecs[1] = '{9'h02A, 1'b0, 8'b0010_1010};
        vecs[2] = '{9'h155, 1'b1, 8'b0101_0101};
        vecs[3] = '{9'h0FF, 1'b0, 8'b1111_1111};
        vecs[4] = '{9'h100, 1'b1, 8'b0000_0000};

        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_busy", busy, 1);
            check("rst_ready", s_ready, 0);
            check("rst_res", lcd_res, 0);
            check("rst_scl", lcd_scl, 0);
            check("rst_sda", lcd_sda, 0);
            check("rst_dc", lcd_dc, 0);
            check("rst_bl", lcd_backlight, 0);
        end
        rst = 1'b0;

        for (int k = 0; k < 30; k++) begin
            check($sformatf("init_res_c%0d", k), lcd_res, (k >= 10) ? 1 : 0);
            check($sformatf("init_ready_c%0d", k), s_ready, 0);
            tick();
        end
        check("init_ready_c30", s_ready, 1);
        check("init_busy_c30", busy, 0);

        for (int i = 0; i < 5; i++) begin
            send_and_watch(vecs[i].data, dc_first, sda_first, scl_first, bits, ready_low, rises,
                           period_bad, dc_changed);
            check($sformatf("v%0d_dc", i), dc_first, vecs[i].exp_dc);
            check($sformatf("v%0d_sda0", i), sda_first, vecs[i].exp_bits[7]);
            check($sformatf("v%0d_scl0", i), scl_first, 0);
            check($sformatf("v%0d_bits", i), bits, vecs[i].exp_bits);
            check($sformatf("v%0d_rises", i), rises, 8);
            check($sformatf("v%0d_ready_low", i), ready_low, 32);
            check($sformatf("v%0d_scl_period", i), period_bad, 0);
            check($sformatf("v%0d_dc_stable", i), dc_changed, 0);
            check($sformatf("v%0d_end_scl", i), lcd_scl, 0);
            check($sformatf("v%0d_hold_sda", i), lcd_sda, vecs[i].exp_bits[0]);
            check($sformatf("v%0d_hold_dc", i), lcd_dc, vecs[i].exp_dc);
        end

        // back-to-back with s_valid held
        s_valid = 1'b1;
        s_data  = 9'h02A;
        tick();
        dc_a   = lcd_dc;
        s_data = 9'h155;
        c   = 0;
        got = 1'b0;
        while (!got && c < 100) begin
            got = s_ready;
            tick();
            c++;
        end
        s_valid = 1'b0;
        check("b2b_gap", c, 33);
        check("b2b_dc_first", dc_a, 0);
        check("b2b_dc_second", lcd_dc, 1);
        wait_ready("b2b_idle_timeout");

        // init_req at SHIFT cycle 9; a second init_req during RST_ASSERT is ignored
        s_valid = 1'b1;
        s_data  = 9'h1FF;
        tick();
        s_valid = 1'b0;
        for (int k = 0; k < 9; k++) tick();
        init_req = 1'b1;
        tick();
        init_req = 1'b0;
        check("abort_scl", lcd_scl, 0);
        check("abort_res", lcd_res, 0);
        check("abort_busy", busy, 1);
        check("abort_ready", s_ready, 0);
        hi = 0;
        res_low = 0;
        for (int k = 0; k < 30; k++) begin
            if (lcd_scl) hi++;
            if (!lcd_res) res_low++;
            if (k == 3) init_req = 1'b1;
            tick();
            init_req = 1'b0;
        end
        check("abort_scl_high_cycles", hi, 0);
        check("abort_res_low_cycles", res_low, 10);
        check("abort_ready_c30", s_ready, 1);
        hi = 0;
        for (int k = 0; k < 20; k++) begin
            if (lcd_scl || busy) hi++;
            tick();
        end
        check("abort_byte_lost", hi, 0);

        // init_req and s_valid in the same IDLE cycle
        init_req = 1'b1;
        s_valid  = 1'b1;
        s_data   = 9'h0C3;
        #1;
        check("prio_ready_low", s_ready, 0);
        tick();
        init_req = 1'b0;
        s_valid  = 1'b0;
        check("prio_busy", busy, 1);
        check("prio_res", lcd_res, 0);
        hi = 0;
        for (int k = 0; k < 30; k++) begin
            if (lcd_scl) hi++;
            tick();
        end
        check("prio_no_shift", hi, 0);
        check("prio_ready_c30", s_ready, 1);

        // backlight PWM
        bl_duty = 8'd64;
        prev = lcd_backlight;
        n = 0;
        while (!(lcd_backlight && !prev) && n < 600) begin
            prev = lcd_backlight;
            tick();
            n++;
        end
        check("pwm_align_timeout", (n < 600) ? 1 : 0, 1);
        hi = 0;
        for (int i = 0; i < 256; i++) begin
            if (lcd_backlight) hi++;
            tick();
        end
        check("pwm_duty64_high", hi, 64);
        hi = 0;
        for (int i = 0; i < 10; i++) begin
            if (lcd_backlight) hi++;
            tick();
        end
        bl_duty = 8'd0;
        for (int i = 10; i < 256; i++) begin
            if (lcd_backlight) hi++;
            tick();
        end
        check("pwm_mid_change_same_period", hi, 64);
        hi = 0;
        for (int i = 0; i < 256; i++) begin
            if (lcd_backlight) hi++;
            tick();
        end
        check("pwm_duty0_high", hi, 0);
        bl_duty = 8'd255;
        hi = 0;
        for (int i = 0; i < 256; i++) begin
            if (lcd_backlight) hi++;
            tick();
        end
        check("pwm_duty255_pending", hi, 0);
        lo = 0;
        for (int i = 0; i < 256; i++) begin
            if (!lcd_backlight) lo++;
            tick();
        end
        check("pwm_duty255_low", lo, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
